// File: rtl/spi_word_receiver.sv
// Receive side of the 3-wire DAC serial link: oversamples CS/SCLK/SDI, assembles MSB-first
// words, flags malformed frames. Optional sequence check enabled by macro SPI_RX_SEQ_CHECK_EN.
module spi_word_receiver #(
    parameter int WORD_WIDTH       = 16,
    parameter int SYNC_STAGES      = 2,
    parameter int EXPECT_INCREMENT = 443
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CS,
    input  logic                  SCLK,
    input  logic                  SDI,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_error,
    output logic [15:0]           word_count,
    output logic                  seq_error
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_CS
    } state_t;

    // Each stage carries {CS, SCLK, SDI} so the three lines stay cycle-aligned.
    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic [SYNC_STAGES-1:0][2:0] sync_next;
    logic [1:0]                  hist_reg;
    logic [SYNC_STAGES:0]        flush_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = {CS, SCLK, SDI};
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    logic cs_s, sclk_s, sdi_s, flush_done;
    assign cs_s       = sync_reg[SYNC_STAGES-1][2];
    assign sclk_s     = sync_reg[SYNC_STAGES-1][1];
    assign sdi_s      = sync_reg[SYNC_STAGES-1][0];
    // The reset value of the chain is not a real sample; edges are only trusted once
    // genuine input has reached both the synced and the history flops.
    assign flush_done = flush_reg[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= {SYNC_STAGES{3'b100}};
            hist_reg  <= 2'b10;
            flush_reg <= '0;
        end else begin
            sync_reg  <= sync_next;
            hist_reg  <= {cs_s, sclk_s};
            flush_reg <= {flush_reg[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edge events are registered once so the FSM acts on flat, aligned flags.
    logic ev_cs_fall_reg, ev_cs_rise_reg, ev_sclk_rise_reg, ev_bit_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_cs_fall_reg   <= 1'b0;
            ev_cs_rise_reg   <= 1'b0;
            ev_sclk_rise_reg <= 1'b0;
            ev_bit_reg       <= 1'b0;
        end else begin
            ev_cs_fall_reg   <= flush_done & hist_reg[1] & ~cs_s;
            ev_cs_rise_reg   <= flush_done & ~hist_reg[1] & cs_s;
            ev_sclk_rise_reg <= flush_done & ~hist_reg[0] & sclk_s;
            ev_bit_reg       <= sdi_s;
        end
    end

    state_t                state_reg, state_next;
    logic [WORD_WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic                  word_done;
    logic                  frame_err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt_reg;
        word_done      = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                shift_next   = '0;
                bit_cnt_next = '0;
                if (ev_cs_fall_reg) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_reg == FULL_CNT) begin
                    // Word is complete; a CS rise in this same cycle still delivers it.
                    word_done = 1'b1;
                    if (ev_sclk_rise_reg && !ev_cs_rise_reg) begin
                        frame_err_next = 1'b1;
                    end
                    state_next = ev_cs_rise_reg ? IDLE : WAIT_CS;
                end else if (ev_cs_rise_reg) begin
                    frame_err_next = (bit_cnt_reg != '0);
                    state_next     = IDLE;
                end else if (ev_sclk_rise_reg) begin
                    shift_next   = {shift_reg[WORD_WIDTH-2:0], ev_bit_reg};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            WAIT_CS: begin
                if (ev_cs_rise_reg) begin
                    state_next = IDLE;
                end else if (ev_sclk_rise_reg) begin
                    frame_err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    logic [WORD_WIDTH-1:0] data_out_reg;
    logic                  data_valid_reg;
    logic                  frame_error_reg;
    logic [15:0]           word_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg    <= '0;
            data_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            word_count_reg  <= '0;
        end else begin
            data_valid_reg  <= word_done;
            frame_error_reg <= frame_err_next;
            if (word_done) begin
                data_out_reg   <= shift_reg;
                word_count_reg <= word_count_reg + 16'd1;
            end
        end
    end

    assign data_out    = data_out_reg;
    assign data_valid  = data_valid_reg;
    assign frame_error = frame_error_reg;
    assign word_count  = word_count_reg;

`ifdef SPI_RX_SEQ_CHECK_EN
    localparam logic [WORD_WIDTH-1:0] INC = WORD_WIDTH'(EXPECT_INCREMENT);

    logic [WORD_WIDTH-1:0] prev_word_reg;
    logic                  first_seen_reg;
    logic                  seq_error_reg;

    // Compared against the word being published so the pulse coincides with data_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_word_reg  <= '0;
            first_seen_reg <= 1'b0;
            seq_error_reg  <= 1'b0;
        end else begin
            seq_error_reg <= 1'b0;
            if (word_done) begin
                seq_error_reg  <= first_seen_reg && (shift_reg != prev_word_reg + INC);
                prev_word_reg  <= shift_reg;
                first_seen_reg <= 1'b1;
            end
        end
    end

    assign seq_error = seq_error_reg;
`else
    assign seq_error = 1'b0;
`endif

endmodule

// File: doc/spi_word_receiver.md
Name: spi_word_receiver

Overview:
- Receive side of the team's 3-wire DAC serial link (CS, SCLK, data), acting as the responder to the word transmitter.
- Oversamples the link on the local clock, assembles MSB-first words, and presents each complete word with a one-cycle valid strobe.
- Flags malformed frames; the word counter and optional sequence check let the bench and the board self-check a ramping source.

Parameters:
- WORD_WIDTH, 16, bits per frame; also the width of data_out.
- SYNC_STAGES, 2, input synchronizer depth (minimum 2) applied identically to CS, SCLK and SDI.
- EXPECT_INCREMENT, 443, expected difference between consecutive words (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- CS  input  1  frame select, active low.
- SCLK  input  1  serial clock; data is sampled on its rising edge.
- SDI  input  1  serial data, MSB first.
- data_out  output  WORD_WIDTH  last complete word; holds until the next complete word.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_error  output  1  one-cycle pulse per malformed-frame event.
- word_count  output  16  count of valid words received; wraps 0xFFFF->0x0000.
- seq_error  output  1  one-cycle pulse on a sequence mismatch (optional feature; 0 otherwise).

Behaviour:
- Reset:
  - data_out=0, data_valid=0, frame_error=0, word_count=0, seq_error=0, state=IDLE.
  - Synchronizer registers reset to CS=1, SCLK=0, SDI=0.
- Synchronization:
  - CS, SCLK and SDI pass through SYNC_STAGES flops plus one history flop each, so the three signals stay cycle-aligned.
  - cs_fall = history high and synced low.
  - cs_rise = history low and synced high.
  - sclk_rise = history low and synced high.
  - The sampled bit is the synced SDI in the cycle sclk_rise is true.
- Timing:
  - SCLK high and low phases of one clk cycle are supported when the source shares clk.
  - Asynchronous sources require at least 2 clk cycles per phase.
- State machine (3 states):
  - IDLE: clear the shift register and bit counter. On cs_fall go to SHIFT. If CS is low out of reset, stay in IDLE until a full high-then-fall has been seen.
  - SHIFT:
    - On sclk_rise: shift_reg = {shift_reg[WORD_WIDTH-2:0], bit} and bit_cnt++.
    - When bit_cnt reaches WORD_WIDTH: on the following cycle, data_out<=shift_reg, data_valid pulses 1 cycle, word_count++; go to WAIT_CS.
    - On cs_rise with 0 < bit_cnt < WORD_WIDTH: pulse frame_error, discard the partial word, go to IDLE.
    - On cs_rise with bit_cnt=0: go to IDLE silently.
  - WAIT_CS:
    - Each sclk_rise pulses frame_error (overrun); the extra bits are ignored and data_out is unchanged.
    - On cs_rise go to IDLE.
- Latency: data_valid asserts exactly SYNC_STAGES+2 clk cycles after the 16th SCLK rising edge is first captured by the first synchronizer stage.
- Simultaneous events: if cs_rise and sclk_rise occur in the same cycle, cs_rise wins and that sclk_rise is not sampled.
- A cs_fall seen in SHIFT or WAIT_CS is impossible without a cs_rise first; none needs handling.
- rst asserted mid-frame: everything returns to reset values on the next edge. The in-flight frame is lost and no error is flagged. Reception resumes at the next CS high-then-fall.

Optional Feature:
- Macro: SPI_RX_SEQ_CHECK_EN.
- Defined:
  - Keep prev_word and first_seen.
  - On each data_valid after the first since reset, pulse seq_error in the same cycle if data_out != prev_word + EXPECT_INCREMENT (mod 2^WORD_WIDTH).
  - Then update prev_word.
  - The first word after reset only seeds prev_word.
- Undefined: seq_error is tied to 0 and no compare or prev_word logic is built.

Test Plan:
- Single frame 0xA5C3, 1-cycle SCLK phases -> data_out=0xA5C3, one data_valid pulse, word_count=1, frame_error=0.
- Ramp of 4 frames 0x0000, 0x01BB, 0x0376, 0x0531 -> 4 valid pulses, word_count=4, seq_error never set (macro on).
- Wrap: frames 0xFFFF then 0x01BA -> seq_error=0, because 0xFFFF+443 wraps to 0x01BA. A next frame of 0x0000 -> seq_error pulses once.
- CS raised after 8 bits of 0xFF00 -> frame_error pulses once, no data_valid, data_out keeps its prior value.
- 17 SCLK edges in one frame 0x1234 -> data_valid once with 0x1234, then frame_error on the 17th edge.
- rst asserted after 10 bits, then a full frame 0x0F0F -> no error, data_out=0x0F0F, word_count=1.
